// File: rtl/instruction_memory.sv
// Byte-addressed Y86-64 instruction memory: combinational 10-byte fetch window, synchronous byte loader.
// Optional macro IMEM_STRICT_BOUNDS_EN flags any fetch window that reaches past the end of memory.
module instruction_memory #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [63:0] pc,
    output logic [7:0]  byte0,
    output logic [7:0]  byte1,
    output logic [7:0]  byte2,
    output logic [7:0]  byte3,
    output logic [7:0]  byte4,
    output logic [7:0]  byte5,
    output logic [7:0]  byte6,
    output logic [7:0]  byte7,
    output logic [7:0]  byte8,
    output logic [7:0]  byte9,
    output logic        imem_error
);

    localparam int          AW    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [64:0] LIMIT = 65'(MEM_BYTES);

    logic [7:0] mem_q [MEM_BYTES];
    logic [7:0] rd_byte [10];
    logic       wr_ok;

    // Out-of-range writes are dropped by comparing the full 64-bit address, not a truncated index.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // 65-bit address sum so pc+N overflow lands out of range instead of wrapping to 0.
    always_comb begin
        logic [64:0] rd_addr;
        rd_addr = '0;
        for (int n = 0; n < 10; n++) begin
            rd_addr    = {1'b0, pc} + 65'(n);
            rd_byte[n] = 8'h00;
            if (!reset && (rd_addr < LIMIT)) begin
                rd_byte[n] = mem_q[rd_addr[AW-1:0]];
            end
        end
    end

    assign byte0 = rd_byte[0];
    assign byte1 = rd_byte[1];
    assign byte2 = rd_byte[2];
    assign byte3 = rd_byte[3];
    assign byte4 = rd_byte[4];
    assign byte5 = rd_byte[5];
    assign byte6 = rd_byte[6];
    assign byte7 = rd_byte[7];
    assign byte8 = rd_byte[8];
    assign byte9 = rd_byte[9];

`ifdef IMEM_STRICT_BOUNDS_EN
    assign imem_error = (({1'b0, pc} + 65'd9) >= LIMIT);
`else
    assign imem_error = ({1'b0, pc} >= LIMIT);
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory against a byte-array reference model.
module tb_instruction_memory;

    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [63:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [63:0] pc = '0;
    logic [7:0]  byte0, byte1, byte2, byte3, byte4, byte5, byte6, byte7, byte8, byte9;
    logic        imem_error;
    logic [7:0]  obs [10];

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [MEM];

    instruction_memory #(.MEM_BYTES(MEM)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc(pc),
        .byte0(byte0), .byte1(byte1), .byte2(byte2), .byte3(byte3), .byte4(byte4),
        .byte5(byte5), .byte6(byte6), .byte7(byte7), .byte8(byte8), .byte9(byte9),
        .imem_error(imem_error)
    );

    always #5 clk = ~clk;

    assign obs[0] = byte0;
    assign obs[1] = byte1;
    assign obs[2] = byte2;
    assign obs[3] = byte3;
    assign obs[4] = byte4;
    assign obs[5] = byte5;
    assign obs[6] = byte6;
    assign obs[7] = byte7;
    assign obs[8] = byte8;
    assign obs[9] = byte9;

    // Reference: a fetched byte is real data only if both pc and pc+n lie inside memory.
    function automatic logic [7:0] exp_byte(input logic [63:0] p, input int n);
        logic [64:0] a;
        a = {1'b0, p} + 65'(n);
        if (p >= 64'(MEM)) return 8'h00;
        if (a >= 65'(MEM)) return 8'h00;
        return ref_mem[a[9:0]];
    endfunction

    function automatic logic exp_err(input logic [63:0] p);
`ifdef IMEM_STRICT_BOUNDS_EN
        return (({1'b0, p} + 65'd9) >= 65'(MEM));
`else
        return (p >= 64'(MEM));
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic write_byte(input logic [63:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (!reset && a < 64'(MEM)) ref_mem[a[9:0]] = d;
    endtask

    task automatic test_reset();
        clear_model();
        #1 reset = 1'b1;
        pc = 64'd0;
        #1;
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (obs[n] !== 8'h00) begin
                errors++;
                $display("FAIL reset_byte%0d got %h want 00", n, obs[n]);
            end
        end
        checks++;
        if (imem_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", imem_error);
        end
        write_byte(64'd5, 8'h30);
        pc = 64'd5;
        #1;
        checks++;
        if (byte0 !== 8'h00) begin
            errors++;
            $display("FAIL write_in_reset got %h want 00", byte0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (byte0 !== 8'h00) begin
            errors++;
            $display("FAIL write_in_reset_after got %h want 00", byte0);
        end
    endtask

    task automatic test_load();
        logic [7:0] prog [10];
        prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) write_byte(64'(i), prog[i]);
        pc = 64'd0;
        #1;
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (obs[n] !== prog[n]) begin
                errors++;
                $display("FAIL load_byte%0d got %h want %h", n, obs[n], prog[n]);
            end
        end
        checks++;
        if (imem_error !== 1'b0) begin
            errors++;
            $display("FAIL load_err got %b want 0", imem_error);
        end
        pc = 64'd1;
        #1;
        checks++;
        if (byte0 !== 8'hF2) begin
            errors++;
            $display("FAIL pc_change got %h want f2", byte0);
        end
    endtask

    task automatic test_boundary();
        logic [63:0] pcs [6];
        pcs = '{64'd1023, 64'd1024, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1014, 64'd1015, 64'hFFFF_FFFF_FFFF_FFF8};
        write_byte(64'd1023, 8'h90);
        write_byte(64'd1022, 8'h21);
        for (int k = 0; k < 6; k++) begin
            pc = pcs[k];
            #1;
            for (int n = 0; n < 10; n++) begin
                checks++;
                if (obs[n] !== exp_byte(pc, n)) begin
                    errors++;
                    $display("FAIL bound_pc%h_byte%0d got %h want %h", pc, n, obs[n], exp_byte(pc, n));
                end
            end
            checks++;
            if (imem_error !== exp_err(pc)) begin
                errors++;
                $display("FAIL bound_err_pc%h got %b want %b", pc, imem_error, exp_err(pc));
            end
        end
    endtask

    task automatic test_same_addr();
        write_byte(64'd20, 8'h10);
        @(negedge clk);
        pc = 64'd20;
        wr_en = 1'b1;
        wr_addr = 64'd20;
        wr_data = 8'h60;
        #1;
        checks++;
        if (byte0 !== 8'h10) begin
            errors++;
            $display("FAIL same_addr_before got %h want 10", byte0);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        ref_mem[20] = 8'h60;
        checks++;
        if (byte0 !== 8'h60) begin
            errors++;
            $display("FAIL same_addr_after got %h want 60", byte0);
        end
    endtask

    task automatic test_oor_write();
        write_byte(64'd2000, 8'hAB);
        write_byte(64'd1029, 8'hCD);
        write_byte(64'h8000_0000_0000_0007, 8'hEE);
        pc = 64'd976;
        #1;
        checks++;
        if (byte0 !== exp_byte(64'd976, 0)) begin
            errors++;
            $display("FAIL oor_976 got %h want %h", byte0, exp_byte(64'd976, 0));
        end
        pc = 64'd0;
        #1;
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (obs[n] !== exp_byte(pc, n)) begin
                errors++;
                $display("FAIL oor_low_byte%0d got %h want %h", n, obs[n], exp_byte(pc, n));
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        for (int i = 0; i < 150; i++) begin
            a = 64'($urandom_range(0, 1100));
            write_byte(a, 8'($urandom));
        end
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 3))
                0: pc = 64'($urandom_range(0, 1023));
                1: pc = 64'($urandom_range(1010, 1030));
                2: pc = {32'($urandom), 32'($urandom)};
                default: pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            endcase
            #1;
            for (int n = 0; n < 10; n++) begin
                checks++;
                if (obs[n] !== exp_byte(pc, n)) begin
                    errors++;
                    $display("FAIL rand_pc%h_byte%0d got %h want %h", pc, n, obs[n], exp_byte(pc, n));
                end
            end
            checks++;
            if (imem_error !== exp_err(pc)) begin
                errors++;
                $display("FAIL rand_err_pc%h got %b want %b", pc, imem_error, exp_err(pc));
            end
        end
    endtask

    task automatic test_async_reset();
        write_byte(64'd0, 8'h30);
        write_byte(64'd3, 8'h44);
        pc = 64'd0;
        #1;
        checks++;
        if (byte0 !== 8'h30) begin
            errors++;
            $display("FAIL pre_reset got %h want 30", byte0);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        clear_model();
        checks++;
        if (byte0 !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got %h want 00", byte0);
        end
        // A write edge that coincides with reset must be lost.
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 64'd3;
        wr_data = 8'h55;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (obs[n] !== exp_byte(pc, n)) begin
                errors++;
                $display("FAIL post_reset_byte%0d got %h want %h", n, obs[n], exp_byte(pc, n));
            end
        end
        pc = 64'($urandom_range(0, 1014));
        #1;
        checks++;
        if (byte0 !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_rand got %h want 00", byte0);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_boundary();
        test_same_addr();
        test_oor_write();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
